// File: rtl/motor_bus_arbiter.sv
// Two-requester arbiter for a strobed register bank: SETUP / STROBE / HOLD bus cycle per grant.
// Define MOTOR_ARB_FIXED_PRIO_EN for fixed req0 priority; the default is round-robin.
`timescale 1ns/1ps
module motor_bus_arbiter #(
  parameter int STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [2:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [2:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_rdata,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [2:0]  addr,
  output logic [31:0] wrdata,
  input  logic [31:0] rddata
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] strobe_cnt;
  logic       lat_write;
  logic       owner;
  logic       req_any;
  logic       grant1;
  logic       accept;

  assign req_any = req0_valid | req1_valid;
  assign accept  = (state == IDLE) && req_any;

`ifdef MOTOR_ARB_FIXED_PRIO_EN
  assign grant1 = req1_valid & ~req0_valid;
`else
  logic last_grant;

  // Ties go to whichever requester was not served last; reset favours req0.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (strobe_cnt == STROBE_LAST) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 strobe_cnt <= '0;
    else if (state != STROBE)   strobe_cnt <= '0;
    else                        strobe_cnt <= strobe_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write  <= 1'b0;
      owner      <= 1'b0;
      addr       <= '0;
      wrdata     <= '0;
      rsp_rdata  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= (state == HOLD) && !owner;
      rsp1_valid <= (state == HOLD) &&  owner;
      if (accept) begin
        owner     <= grant1;
        lat_write <= grant1 ? req1_write : req0_write;
        addr      <= grant1 ? req1_addr  : req0_addr;
        wrdata    <= grant1 ? req1_wdata : req0_wdata;
      end
      if (state == HOLD && !lat_write) rsp_rdata <= rddata;
    end
  end

  // Ready is gated by rst_n so a pending request cannot show an accept while reset is held.
  always_comb begin
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = rst_n && req_any && !grant1;
        req1_ready = rst_n && grant1;
      end
      SETUP, HOLD: cs_n = 1'b0;
      STROBE: begin
        cs_n = 1'b0;
        rd_n = lat_write;
        wr_n = !lat_write;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/motor_bus_arbiter.md
MOTOR_BUS_ARBITER -- requirements
Module: motor_bus_arbiter

Interface
REQ-001 Parameter: STROBE_CYC, default 2, low-time of rd_n/wr_n in clk cycles (legal 1..15).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid, req1_valid  input  1 each  request pending; req0 = host CPU, req1 = control-loop engine.
REQ-005 req0_write, req1_write  input  1 each  1 = write, 0 = read.
REQ-006 req0_addr, req1_addr  input  3 each  register-bank address.
REQ-007 req0_wdata, req1_wdata  input  32 each  write payload.
REQ-008 req0_ready, req1_ready  output  1 each  one-cycle accept pulse; payload is sampled in that cycle.
REQ-009 rsp0_valid, rsp1_valid  output  1 each  one-cycle completion pulse.
REQ-010 rsp_rdata  output  32  read result; valid while rspN_valid is high (read transactions only).
REQ-011 cs_n, rd_n, wr_n  output  1 each  active-low register-bank strobes.
REQ-012 addr  output  3  bank address.
REQ-013 wrdata  output  32  bank write data.
REQ-014 rddata  input  32  bank read data; the bank registers it one edge after sampling rd_n and cs_n low.

Function
REQ-015 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-016 IDLE, any reqN_valid high:
- pulse the winner's reqN_ready.
- latch the winner's write, addr and wdata, plus the winner ID.
- go to SETUP next cycle.
REQ-017 IDLE with no request: hold all strobes high and stay in IDLE.
REQ-018 SETUP, exactly 1 cycle: cs_n=0, addr and wrdata driven from latched values, rd_n=wr_n=1.
REQ-019 STROBE, exactly STROBE_CYC cycles (counted by a 4-bit counter): cs_n=0, and rd_n=0 (read) or wr_n=0 (write); the other strobe stays 1.
REQ-020 HOLD, exactly 1 cycle: cs_n=0, rd_n=wr_n=1; for reads, rddata is captured into rsp_rdata at the edge ending HOLD.
REQ-021 Completion: the cycle after HOLD, state is IDLE and the owner's rspN_valid pulses for 1 cycle.
REQ-022 Completion/grant overlap: a new grant may occur in that same IDLE cycle, so there are no idle bubbles between back-to-back transactions.
REQ-023 Transaction occupancy: STROBE_CYC+3 cycles from ready pulse to rsp_valid pulse.
REQ-024 addr and wrdata hold stable from SETUP through HOLD; requester inputs after the ready pulse are ignored until the next grant.
REQ-025 Arbitration (default), round-robin:
- both valid in IDLE: grant the requester not granted last.
- after reset, req0 has priority.
REQ-026 A single valid requester is always granted, whatever the last-grant state.
REQ-027 The arbiter passes addresses 5..7 unchanged; a write completes normally and a read returns whatever rddata holds.
REQ-028 rsp_rdata holds its value between reads; write completions leave it unchanged.
REQ-029 Never more than one of rd_n, wr_n low; never rd_n or wr_n low while cs_n is high.

Reset
REQ-030 On rst_n low (asynchronous), including mid-transaction:
- state=IDLE, cs_n=rd_n=wr_n=1, addr=0, wrdata=0, rsp_rdata=0.
- all ready and rsp_valid outputs = 0.
- last-grant = req1, so req0 wins first.
REQ-031 An aborted transaction is never completed; no rsp_valid pulse follows reset release.
REQ-032 After reset release, the first grant can occur at the first clk edge with rst_n high.

Configuration
REQ-033 Macro MOTOR_ARB_FIXED_PRIO_EN:
- defined: req0 always wins simultaneous requests, and the last-grant register is not implemented.
- undefined: round-robin per REQ-025.

Verification
REQ-034 Read, STROBE_CYC=2: req1 read addr 3, bank rddata=32'h0000_1234 ->
- req1_ready at cycle 0.
- cs_n low cycles 1-4, rd_n low cycles 2-3.
- rsp1_valid at cycle 5 with rsp_rdata=32'h0000_1234.
REQ-035 Write: req0 write addr 0, wdata=32'd170 -> wr_n low 2 cycles with addr=0 and wrdata=170 stable SETUP through HOLD; rsp0_valid 5 cycles after the ready pulse; rsp_rdata unchanged.
REQ-036 Contention, both valid continuously, macro undefined -> grant sequence 0,1,0,1; consecutive ready pulses 5 cycles apart; rsp and ready coincide in the shared IDLE cycle.
REQ-037 Contention, macro defined -> req0 granted every time; req1 granted only on the first IDLE with req0_valid low.
REQ-038 rst_n asserted during STROBE of a write -> wr_n and cs_n high immediately (asynchronous); no rsp_valid after release; next simultaneous request grants req0.
REQ-039 STROBE_CYC=1, read addr 2 -> rd_n low exactly 1 cycle; captured rsp_rdata equals the bank value for addr 2; ready-to-rsp latency 4 cycles.
